// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the memory access unit: transfer sizes,
// FSM states, timeout limit, alignment check, byte enables and store lane replication.
package mem_access_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // Reserved size and misaligned half/word accesses are rejected before touching memory.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = 4'b0011 << off;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SIZE_B:  rep = {4{wdata[7:0]}};
      SIZE_H:  rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data path: picks the addressed byte/half lane out of the read word and
// zero- or sign-extends it to 32 bits; words pass through unchanged.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension
  always_comb begin
    byte_s = 8'h00;
    half_s = off[1] ? rdata[31:16] : rdata[15:0];
    data   = 32'h0000_0000;
    case (off)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    case (size)
      SIZE_B:  data = {{24{sign & byte_s[7]}}, byte_s};
      SIZE_H:  data = {{16{sign & half_s[15]}}, half_s};
      SIZE_W:  data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit bridging byte-addressed requests to a word memory.
// Optional MEM_ACCESS_TIMEOUT_EN aborts an unacknowledged access after 255 ACCESS cycles.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_e      state_r;
  state_e      state_next_s;
  logic        we_r;
  logic        sign_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic        err_r;
  logic [31:0] data_r;
  logic [31:0] load_data_s;
  logic        illegal_s;
  logic        abort_s;

  assign illegal_s = is_illegal(req_size, req_addr[1:0]);

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Counts unacknowledged ACCESS cycles; held at zero while idle so each access starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r != ST_ACCESS) begin
      tmo_cnt_r <= 8'd0;
    end else if (!mem_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end
  end

  assign abort_s = (state_r == ST_ACCESS) && !mem_ack && (tmo_cnt_r == TIMEOUT_LIMIT - 8'd1);
`else
  assign abort_s = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata (mem_rdata),
    .off   (off_r),
    .size  (size_r),
    .sign  (sign_r),
    .data  (load_data_s)
  );

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = req_valid ? (illegal_s ? ST_RESP : ST_ACCESS) : ST_IDLE;
      ST_ACCESS: state_next_s = (mem_ack || abort_s) ? ST_RESP : ST_ACCESS;
      ST_RESP:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register, request latch, memory-side and response-side output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      req_ready <= 1'b1;
      we_r      <= 1'b0;
      sign_r    <= 1'b0;
      size_r    <= SIZE_B;
      off_r     <= 2'b00;
      err_r     <= 1'b0;
      data_r    <= 32'h0000_0000;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      req_ready <= (state_next_s == ST_IDLE);
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r   <= req_we;
            sign_r <= req_sign;
            size_r <= req_size;
            off_r  <= req_addr[1:0];
            err_r  <= illegal_s;
            data_r <= 32'h0000_0000;
            if (!illegal_s) begin
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= byte_enables(req_size, req_addr[1:0]);
              mem_wdata <= lane_replicate(req_size, req_wdata);
            end
          end
        end
        ST_ACCESS: begin
          // A timeout abort completes like an ack but reports an error with no data
          if (mem_ack || abort_s) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'b0000;
            err_r  <= !mem_ack;
            data_r <= (we_r || !mem_ack) ? 32'h0000_0000 : load_data_s;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_r;
          rsp_rdata <= data_r;
        end
        default: begin
          mem_en <= 1'b0;
          mem_be <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses,
// a monitor pops and compares on every rsp_valid.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b expected no response at %0t",
                 rsp_rdata, rsp_err, $time);
      end else begin
        logic [32:0] exp;
        exp = sb_q.pop_front();
        if ({rsp_err, rsp_rdata} !== exp) begin
          errors++;
          $display("FAIL rsp: got err %0b rdata 0x%08h expected err %0b rdata 0x%08h at %0t",
                   rsp_err, rsp_rdata, exp[32], exp[31:0], $time);
        end
      end
    end
  end

  // Issue one request at a negedge and walk it through to the response pulse.
  task automatic run_access(input logic we, input logic [1:0] size, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input logic legal,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
    sb_q.push_back({exp_err, exp_rdata});
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // scramble request inputs to prove the unit latched them
    req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_sign = ~sign;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (legal) begin
      for (int i = 0; i <= waits; i++) begin
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        if (we) chk("mem_wdata", mem_wdata, exp_wdata);
        if (i < waits) @(negedge clk);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    end
    chk("mem_en_off", 32'(mem_en), 32'd0);
    chk("mem_be_off", 32'(mem_be), 32'd0);
    chk("rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_latency", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("rsp_err_hold", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata_hold", rsp_rdata, exp_rdata);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // ack while idle is ignored
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_ready", 32'(req_ready), 32'd1);
    chk("idle_ack_mem_en", 32'(mem_en), 32'd0);

    //          we    size   sign  addr          wdata         rdata         w  legal be       exp_wdata     exp_rdata     err
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,       32'h80FF_0000, 0, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,      1'b0);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,       32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_access(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,       32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,       32'h0000_8001, 3, 1'b1, 4'b0011, 32'h0,        32'h0000_8001, 1'b0);
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,       32'h8001_1234, 0, 1'b1, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,       32'h0000_9A00, 2, 1'b1, 4'b0010, 32'h0,        32'h0000_009A, 1'b0);
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00A5, 32'h0,       0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0);
    run_access(1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0,       32'hCAFE_F00D, 1, 1'b1, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,       0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0,       0, 1'b1, 4'b1111, 32'h1122_3344, 32'h0,        1'b0);

    // reset in the second ACCESS cycle abandons the access silently
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_be", 32'(mem_be), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // no ack: abort after 255 ACCESS cycles, response seen 257 negedges after issue
    sb_q.push_back({1'b1, 32'h0});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0020;
    cnt = 0;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    while (rsp_valid !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_latency", 32'(cnt), 32'd257);
    @(negedge clk);
    chk("timeout_idle", 32'(req_ready), 32'd1);
    chk("timeout_rdata", rsp_rdata, 32'h0);
    chk("timeout_err", 32'(rsp_err), 32'd1);
`else
    // without the timeout the unit waits indefinitely for ack
    sb_q.push_back({1'b0, 32'h0000_0077});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h0000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (mem_en === 1'b1 && rsp_valid === 1'b0) cnt++;
      @(negedge clk);
    end
    chk("no_timeout_wait", 32'(cnt), 32'd300);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_done_rdata", rsp_rdata, 32'h0000_0077);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: req_valid  in  1  access request; req_ready  out  1  unit idle, request accepted when both high.
REQ-004 SHALL have ports: req_we  in  1  1 store / 0 load; req_size  in  2  00 byte, 01 half, 10 word, 11 reserved; req_sign  in  1  sign-extend load.
REQ-005 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-006 SHALL have ports: mem_en  out  1; mem_we  out  1; mem_addr  out  32  word address {addr[31:2],2'b00}; mem_be  out  4  byte enables; mem_wdata  out  32  lane-replicated data.
REQ-007 SHALL have ports: mem_rdata  in  32  read word; mem_ack  in  1  memory completes access this cycle.
REQ-008 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  extended load data; rsp_err  out  1  error flag, valid with rsp_valid.

Function
REQ-009 SHALL implement FSM IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE on req_valid, latch all req_* fields; go to ACCESS if aligned and size legal, else to RESP with error latched and no memory access.
REQ-011 SHALL treat as misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11 always error.
REQ-012 SHALL in ACCESS drive mem_en=1, mem_we=latched we, hold mem_addr/mem_be/mem_wdata stable until the cycle mem_ack=1.
REQ-013 SHALL generate mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_be=0 outside ACCESS.
REQ-014 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-015 SHALL on mem_ack in ACCESS register rsp_rdata from mem_rdata lane selected by addr[1:0], zero- or sign-extended per req_sign (byte/half), word unchanged; go to RESP.
REQ-016 SHALL drive rsp_rdata=0 for stores and errored accesses.
REQ-017 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata/rsp_err hold until next response.
REQ-018 SHALL give load latency: accept at edge N, ack in first ACCESS cycle -> rsp_valid high in cycle after edge N+2; each extra wait cycle adds one.
REQ-019 SHALL ignore mem_ack outside ACCESS and req_valid outside IDLE.

Reset
REQ-020 SHALL on reset=1 at any edge, including mid-ACCESS, enter IDLE and clear mem_en, mem_we, mem_be, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata to 0; req_ready=1 after reset.
REQ-021 SHALL NOT complete or report an access aborted by reset.

Configuration
REQ-022 SHALL honour macro MEM_ACCESS_TIMEOUT_EN: when defined, an 8-bit counter clears on ACCESS entry, increments per ACCESS cycle without ack, and at 255 aborts to RESP with rsp_err=1, rsp_rdata=0.
REQ-023 SHALL, without MEM_ACCESS_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely for mem_ack.

Structure
REQ-024 SHALL place size encodings (SIZE_B/H/W), FSM state encodings and timeout limit constant in shared package mem_access_pkg.
REQ-025 SHALL instantiate one combinational sub-module load_extend (lane select plus sign/zero extension) for REQ-015.

Verification
REQ-026 SHALL cover: load byte signed, addr 0x1003, mem_rdata 0x80FF_0000, ack first cycle -> mem_be 0000 during ACCESS except be=1000 (read), rsp_rdata 0xFFFF_FF80, rsp_valid 2 cycles after accept.
REQ-027 SHALL cover: store half addr 0x2002, wdata 0x1234_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we=1, rsp_rdata 0, rsp_err 0.
REQ-028 SHALL cover: load word addr 0x0006 -> no mem_en assertion, rsp_valid with rsp_err=1; size 11 same result.
REQ-029 SHALL cover: load half unsigned addr 0x0000, mem_ack delayed 3 cycles, mem_rdata 0x0000_8001 -> outputs stable throughout, rsp_rdata 0x0000_8001.
REQ-030 SHALL cover: reset asserted in second ACCESS cycle -> next cycle IDLE, mem_en 0, no rsp_valid.
REQ-031 SHALL cover, with MEM_ACCESS_TIMEOUT_EN: no ack for 255 ACCESS cycles -> rsp_err=1, rsp_rdata 0, return to IDLE.
